// File: rtl/yutorina_bus_mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage bus controller: memory ops,
// misalignment codes, bus direction and controller FSM states.
package yutorina_bus_mem_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_R_B  = 4'd1,
        OP_R_BU = 4'd2,
        OP_R_H  = 4'd3,
        OP_R_HU = 4'd4,
        OP_R_W  = 4'd5,
        OP_W_B  = 4'd6,
        OP_W_H  = 4'd7,
        OP_W_W  = 4'd8
    } mem_op_e;

    localparam logic [1:0] MISS_ALIGN_NONE  = 2'd0;
    localparam logic [1:0] MISS_ALIGN_LOAD  = 2'd1;
    localparam logic [1:0] MISS_ALIGN_STORE = 2'd2;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_R_B) || (op == OP_R_BU) || (op == OP_R_H) ||
               (op == OP_R_HU) || (op == OP_R_W);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_W_B) || (op == OP_W_H) || (op == OP_W_W);
    endfunction

    function automatic logic is_byte(input logic [3:0] op);
        return (op == OP_R_B) || (op == OP_R_BU) || (op == OP_W_B);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == OP_R_H) || (op == OP_R_HU) || (op == OP_W_H);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_R_W) || (op == OP_W_W);
    endfunction

endpackage

// File: rtl/yutorina_mem_lane.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// lane extraction plus sign/zero extension on the way in.
module yutorina_mem_lane
    import yutorina_bus_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8,
    localparam int OFS_W = $clog2(BE_W)
) (
    input  logic [3:0]        op,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] r_data,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] ld_data
);

    logic [15:0] lane_lo;

    always_comb begin
        // Only the low halfword of the shifted word is ever needed.
        lane_lo = 16'(r_data >> {ofs, 3'b000});
        be      = '0;
        wr_data = st_data;
        ld_data = '0;
        if (is_byte(op)) begin
            be      = BE_W'(1) << ofs;
            wr_data = {BE_W{st_data[7:0]}};
            ld_data = (op == OP_R_B) ? {{(DATA_W-8){lane_lo[7]}}, lane_lo[7:0]}
                                     : {{(DATA_W-8){1'b0}}, lane_lo[7:0]};
        end else if (is_half(op)) begin
            be      = BE_W'(3) << ofs;
            wr_data = {(BE_W/2){st_data[15:0]}};
            ld_data = (op == OP_R_H) ? {{(DATA_W-16){lane_lo[15]}}, lane_lo}
                                     : {{(DATA_W-16){1'b0}}, lane_lo};
        end else if (is_word(op)) begin
            be      = '1;
            ld_data = r_data;
        end
    end

endmodule

// File: rtl/yutorina_bus_mem_ctrl.sv
// MEM-stage controller: issues one wait-state bus cycle per aligned load/store,
// stalls the pipeline until ready (or timeout) and flags misaligned accesses.
module yutorina_bus_mem_ctrl
    import yutorina_bus_mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255,
    localparam int BE_W   = DATA_W / 8,
    localparam int OFS_W  = $clog2(BE_W)
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              ex_en_,
    input  logic [3:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_out,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic              bus_rdy_,
    input  logic [DATA_W-1:0] bus_r_data,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] out,
    output logic [1:0]        miss_align,
    output logic              bus_err,
    output logic              stall
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [3:0]          op_q, op_d;
    logic [OFS_W-1:0]    ofs_q, ofs_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                err_q, err_d;

    logic [OFS_W-1:0]    ofs;
    logic                ld_req, st_req, req, mis, go;
    logic [BE_W-1:0]     st_be;
    logic [DATA_W-1:0]   st_wr_data, ld_data;
    logic [BE_W-1:0]     ld_be_unused;
    logic [DATA_W-1:0]   ld_wd_unused, st_ld_unused;

    yutorina_mem_lane #(.DATA_W(DATA_W)) u_st_lane (
        .op      (ex_mem_op),
        .ofs     (ofs),
        .st_data (ex_st_data),
        .r_data  ('0),
        .be      (st_be),
        .wr_data (st_wr_data),
        .ld_data (st_ld_unused)
    );

    yutorina_mem_lane #(.DATA_W(DATA_W)) u_ld_lane (
        .op      (op_q),
        .ofs     (ofs_q),
        .st_data ('0),
        .r_data  (bus_r_data),
        .be      (ld_be_unused),
        .wr_data (ld_wd_unused),
        .ld_data (ld_data)
    );

    always_comb begin
        ofs    = ex_out[OFS_W-1:0];
        ld_req = is_load(ex_mem_op);
        st_req = is_store(ex_mem_op);
        req    = !ex_en_ && (ld_req || st_req);
        mis    = 1'b0;
        if (is_half(ex_mem_op))
            mis = ex_out[0];
        else if (is_word(ex_mem_op))
            mis = (ofs != '0);
        go = (state_q == ST_IDLE) && req && !mis;
    end

    always_ff @(posedge clk) begin
        if (!reset_)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go) state_d = ST_BUS;
            ST_BUS: begin
                if (!bus_rdy_)
                    state_d = ST_DONE;
                else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        be_d      = be_q;
        rw_d      = rw_q;
        wr_data_d = wr_data_q;
        op_d      = op_q;
        ofs_d     = ofs_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    addr_d    = ex_out[OFS_W +: ADDR_W];
                    be_d      = st_be;
                    rw_d      = ld_req ? READ : WRITE;
                    wr_data_d = st_wr_data;
                    op_d      = ex_mem_op;
                    ofs_d     = ofs;
                    cnt_d     = '0;
                end
            end
            ST_BUS: begin
                if (!bus_rdy_) begin
                    if (rw_q == READ)
                        rd_d = ld_data;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d = 1'b1;
                    rd_d  = '0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: err_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            addr_q    <= '0;
            be_q      <= '0;
            rw_q      <= READ;
            wr_data_q <= '0;
            op_q      <= OP_NOP;
            ofs_q     <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            be_q      <= be_d;
            rw_q      <= rw_d;
            wr_data_q <= wr_data_d;
            op_q      <= op_d;
            ofs_q     <= ofs_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        bus_as_     = (state_q != ST_BUS);
        bus_rw      = rw_q;
        bus_addr    = addr_q;
        bus_be      = be_q;
        bus_wr_data = wr_data_q;
        bus_err     = (state_q == ST_DONE) && err_q;
        stall       = (state_q == ST_BUS) || go;
        miss_align  = MISS_ALIGN_NONE;
        out         = ex_out;
        if ((state_q == ST_IDLE) && req && mis) begin
            miss_align = ld_req ? MISS_ALIGN_LOAD : MISS_ALIGN_STORE;
            out        = '0;
        end else if ((state_q == ST_DONE) && (rw_q == READ)) begin
            out = rd_q;
        end
    end

endmodule

// File: tb/tb_yutorina_bus_mem_ctrl.sv
// Directed bench for yutorina_bus_mem_ctrl with a bus responder driven from
// the stimulus task and a scoreboard of expected WB results.
module tb_yutorina_bus_mem_ctrl;
    import yutorina_bus_mem_ctrl_pkg::*;

    logic        clk;
    logic        reset_;
    logic        ex_en_;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_out;
    logic [31:0] ex_st_data;
    logic        bus_rdy_;
    logic [31:0] bus_r_data;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [3:0]  bus_be;
    logic [31:0] out;
    logic [1:0]  miss_align;
    logic        bus_err;
    logic        stall;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [31:0] out;
        logic        chk_out;
        logic        err;
    } exp_t;
    exp_t sb[$];

    yutorina_bus_mem_ctrl #(.DATA_W(32), .ADDR_W(30), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .ex_en_      (ex_en_),
        .ex_mem_op   (ex_mem_op),
        .ex_out      (ex_out),
        .ex_st_data  (ex_st_data),
        .bus_rdy_    (bus_rdy_),
        .bus_r_data  (bus_r_data),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_be      (bus_be),
        .out         (out),
        .miss_align  (miss_align),
        .bus_err     (bus_err),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory access: drive the request, answer the bus after 'waits'
    // wait states, and compare the DONE-cycle result against the scoreboard.
    task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_out, input logic exp_err,
                          input int exp_stall, input int exp_strobes);
        exp_t e;
        exp_t got;
        int   stalls  = 0;
        int   strobes = 0;
        bit   done    = 1'b0;
        logic [29:0] exp_addr;
        exp_addr = addr[31:2];
        @(posedge clk); #1;
        ex_en_     = 1'b0;
        ex_mem_op  = op;
        ex_out     = addr;
        ex_st_data = sdata;
        bus_rdy_   = 1'b1;
        bus_r_data = '0;
        e.out     = exp_out;
        e.chk_out = is_load(op);
        e.err     = exp_err;
        sb.push_back(e);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (!bus_as_) begin
                strobes++;
                check({tag, "_addr"}, 32'(bus_addr), 32'(exp_addr));
                if (strobes == 1) begin
                    check({tag, "_be"}, 32'(bus_be), 32'(exp_be));
                    check({tag, "_rw"}, 32'(bus_rw), 32'(is_load(op)));
                    if (is_store(op))
                        check({tag, "_wdata"}, bus_wr_data, exp_wd);
                end
                bus_rdy_   = (strobes > waits) ? 1'b0 : 1'b1;
                bus_r_data = rdata;
                ex_out     = ~addr;
                ex_st_data = ~sdata;
            end
            if (stall) begin
                stalls++;
            end else if (stalls > 0) begin
                done = 1'b1;
                got = sb.pop_front();
                if (got.chk_out)
                    check({tag, "_out"}, out, got.out);
                check({tag, "_err"}, 32'(bus_err), 32'(got.err));
                check({tag, "_as_done"}, 32'(bus_as_), 32'd1);
            end
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
        $display("txn %s op=%0d addr=%h out=%h err=%0b stalls=%0d strobes=%0d",
                 tag, op, addr, out, bus_err, stalls, strobes);
    endtask

    task automatic idle_check(input string tag, input logic [31:0] val);
        @(posedge clk); #1;
        ex_en_    = 1'b1;
        ex_mem_op = OP_NOP;
        ex_out    = val;
        bus_rdy_  = 1'b1;
        @(negedge clk);
        check({tag, "_out"}, out, val);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_as"}, 32'(bus_as_), 32'd1);
        check({tag, "_err"}, 32'(bus_err), 32'd0);
        check({tag, "_ma"}, 32'(miss_align), 32'(MISS_ALIGN_NONE));
        $display("txn %s idle out=%h", tag, out);
    endtask

    task automatic misaligned(input string tag, input logic [3:0] op, input logic [31:0] addr,
                              input logic [1:0] exp_ma);
        @(posedge clk); #1;
        ex_en_     = 1'b0;
        ex_mem_op  = op;
        ex_out     = addr;
        ex_st_data = 32'h1234_5678;
        @(negedge clk);
        check({tag, "_ma"}, 32'(miss_align), 32'(exp_ma));
        check({tag, "_as"}, 32'(bus_as_), 32'd1);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_out"}, out, 32'd0);
        @(posedge clk); #1;
        ex_en_ = 1'b1;
        @(negedge clk);
        check({tag, "_as_after"}, 32'(bus_as_), 32'd1);
        $display("txn %s misaligned op=%0d addr=%h", tag, op, addr);
    endtask

    initial begin
        reset_     = 1'b0;
        ex_en_     = 1'b1;
        ex_mem_op  = OP_NOP;
        ex_out     = 32'h0000_ABCD;
        ex_st_data = '0;
        bus_rdy_   = 1'b0;
        bus_r_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_as", 32'(bus_as_), 32'd1);
        check("rst_rw", 32'(bus_rw), 32'd1);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_wdata", bus_wr_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_ma", 32'(miss_align), 32'(MISS_ALIGN_NONE));
        check("rst_out", out, 32'h0000_ABCD);
        @(posedge clk); #1;
        reset_ = 1'b1;
        @(negedge clk);
        check("idle_rdy_ignored_as", 32'(bus_as_), 32'd1);

        access("rb",  OP_R_B,  32'h1003, 0, 32'h8000_0000, 0, 4'b1000, 0, 32'hFFFF_FF80, 0, 2, 1);
        access("rbu", OP_R_BU, 32'h1003, 0, 32'h8000_0000, 0, 4'b1000, 0, 32'h0000_0080, 0, 2, 1);
        access("rh",  OP_R_H,  32'h1002, 0, 32'h8001_0000, 0, 4'b1100, 0, 32'hFFFF_8001, 0, 2, 1);
        access("rhu", OP_R_HU, 32'h1002, 0, 32'h8001_0000, 1, 4'b1100, 0, 32'h0000_8001, 0, 3, 2);
        access("wh",  OP_W_H,  32'h2002, 32'h1234, 0, 3, 4'b1100, 32'h1234_1234, 0, 0, 5, 4);
        access("wb",  OP_W_B,  32'h3001, 32'hA5, 0, 1, 4'b0010, 32'hA5A5_A5A5, 0, 0, 3, 2);
        access("ww",  OP_W_W,  32'h3004, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'hCAFE_F00D, 0, 0, 2, 1);

        misaligned("ma_rw", OP_R_W, 32'h2001, MISS_ALIGN_LOAD);
        misaligned("ma_wh", OP_W_H, 32'h2001, MISS_ALIGN_STORE);
        misaligned("ma_ww", OP_W_W, 32'h2002, MISS_ALIGN_STORE);

        access("tmo", OP_R_W, 32'h5000, 0, 32'h1234_5678, 100, 4'b1111, 0, 32'h0, 1, 5, 4);
        idle_check("tmo_after", 32'h77);

        // Reset asserted during the second BUS cycle abandons the access.
        @(posedge clk); #1;
        ex_en_    = 1'b0;
        ex_mem_op = OP_R_W;
        ex_out    = 32'h6000;
        bus_rdy_  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rstbus_as_bus2", 32'(bus_as_), 32'd0);
        reset_ = 1'b0;
        ex_en_ = 1'b1;
        @(negedge clk);
        check("rstbus_as", 32'(bus_as_), 32'd1);
        check("rstbus_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset_ = 1'b1;
        @(negedge clk);
        check("rstbus_idle_as", 32'(bus_as_), 32'd1);
        $display("txn rstbus reset during bus cycle");
        access("rw_after_rst", OP_R_W, 32'h6000, 0, 32'h0BAD_F00D, 2, 4'b1111, 0, 32'h0BAD_F00D, 0, 4, 3);

        access("b2b_0", OP_R_W, 32'h4000, 0, 32'hDEAD_BEEF, 0, 4'b1111, 0, 32'hDEAD_BEEF, 0, 2, 1);
        access("b2b_1", OP_R_B, 32'h4001, 0, 32'h0000_7F00, 0, 4'b0010, 0, 32'h0000_007F, 0, 2, 1);
        idle_check("nop", 32'h55);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/yutorina_bus_mem_ctrl.md
# yutorina_bus_mem_ctrl

Parametrised MEM-stage memory access controller: the successor to the single-cycle word-only controller. It adds byte, halfword and word loads and stores, and sign or zero extension of loads. It drives a wait-state bus with byte enables and a ready handshake, stalls the pipeline until the access completes, and flags alignment errors and bus timeouts. It sits between the EX/MEM pipeline register and the data-memory bus.

## Interface
Parameters:
- `DATA_W`, 32: bus and register width; only 32 and 64 are legal. `BE_W = DATA_W/8`. `OFS_W = log2(BE_W)`.
- `ADDR_W`, 30: bus word-address width.
- `TIMEOUT`, 255: bus cycles waited for ready before aborting. 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `reset_` in 1: synchronous, active-low reset.
- `ex_en_` in 1: EX/MEM stage valid, active-low.
- `ex_mem_op` in 4: memory op. Encodings are NOP, R_B, R_BU, R_H, R_HU, R_W, W_B, W_H, W_W. "W" means the full `DATA_W` width.
- `ex_out` in `DATA_W`: ALU result. This is the byte address for memory ops and the pass-through value otherwise.
- `ex_st_data` in `DATA_W`: store data, right-aligned.
- `bus_rdy_` in 1: bus ready, active-low.
- `bus_r_data` in `DATA_W`: bus read data.
- `bus_as_` out 1: address strobe, active-low.
- `bus_rw` out 1: 1 means READ, 0 means WRITE.
- `bus_addr` out `ADDR_W`: word address, `ex_out[OFS_W +: ADDR_W]`.
- `bus_wr_data` out `DATA_W`: store data replicated into every lane.
- `bus_be` out `BE_W`: byte enables.
- `out` out `DATA_W`: result to WB.
- `miss_align` out 2: NONE, LOAD or STORE.
- `bus_err` out 1: timeout abort.
- `stall` out 1: freezes IF through EX/MEM.

## Operation
- A request is `ex_en_ == 0` with a load or store op.
- Alignment rules:
  - Halfword is misaligned when `ex_out[0] != 0`.
  - Word is misaligned when `ex_out[OFS_W-1:0] != 0`.
  - Byte ops are never misaligned.
- Misaligned request: no bus cycle, `stall = 0`, `out = 0`, and `miss_align` is LOAD or STORE. These outputs are combinational in the same cycle.
- Non-memory op or `ex_en_ == 1`: `out = ex_out`, `stall = 0`, `miss_align = NONE`, and the bus stays idle.
- Lane selection uses `ofs = ex_out[OFS_W-1:0]`.
  - Byte access: `be = 1 << ofs`.
  - Halfword access: `be = 3 << ofs`.
  - Word access: `be` is all ones.
- Loads extract the lane at `ofs*8`. R_B and R_H sign-extend, R_BU and R_HU zero-extend, and R_W passes the data through.
- Stores drive `bus_wr_data` with the byte replicated to every byte lane or the halfword replicated to every halfword lane. W_W drives the data as-is.
- FSM with states IDLE, BUS and DONE:
  - **IDLE**: an aligned request sets `stall = 1` combinationally. The controller latches addr, be, rw, wr_data, op and ofs, clears the wait counter, and goes to BUS.
  - **BUS**: `bus_as_ = 0`, `stall = 1`, and the latched values are driven.
    - If `bus_rdy_ == 0`, load data is extended into `rd_q` (stores leave it untouched) and the FSM goes to DONE.
    - Otherwise, if `TIMEOUT != 0` and the counter equals `TIMEOUT-1`, the controller sets `err_q`, forces `rd_q = 0` and goes to DONE.
    - Otherwise the counter increments.
  - **DONE**: `stall = 0`, `bus_as_ = 1`, `out = rd_q` for loads, `bus_err = err_q`. The pipeline advances at the end of this cycle, so the same request is never reissued. The FSM then goes to IDLE and clears `err_q`.
- The wait counter width is `$clog2(TIMEOUT+1)` and it saturates; it never wraps.

## Timing
- Reset state: IDLE, `bus_as_ = 1`, `bus_rw = 1`, `bus_be = 0`, `bus_addr = 0`, `bus_wr_data = 0`, `rd_q = 0`, `err_q = 0`, counter 0. This gives `stall = 0`, `bus_err = 0`, `miss_align = NONE`, and `out = ex_out`.
- Reset in BUS or DONE returns to IDLE on the next edge. `bus_as_` is high from that edge on and the access is abandoned.
- Zero-wait access (ready low in the first BUS cycle): the request cycle, one BUS cycle and one DONE cycle, so `stall` is high for 2 cycles.
- Each wait state adds one BUS cycle.
- Timeout abort: `TIMEOUT` BUS cycles, then DONE with `bus_err = 1` for exactly one cycle.
- `bus_rdy_` is sampled only in BUS. Ready arriving in IDLE or DONE is ignored.
- Inputs may change while `stall = 1`; only the latched copies are used in BUS.

## Structure
- The shared header holds:
  - the op encodings,
  - the `MISS_ALIGN_*` codes,
  - READ/WRITE,
  - the FSM state encodings.
- One sub-module, `yutorina_mem_lane`, is combinational. It produces `be` and replicated `wr_data` from op, ofs and data, and the extracted, extended load value from op, ofs and `r_data`. It is instantiated once for stores and once for loads.

## Test plan
- R_B with `ex_out = 0x1003`, zero-wait, lane 3 read data `0x80`:
  - `bus_be = 4'b1000`, `bus_addr = 0x400`.
  - In DONE, `out = 0xFFFFFF80`; with R_BU, `out = 0x00000080`.
  - `stall` is high for 2 cycles.
- W_H with `ex_out = 0x2002`, `ex_st_data = 0x1234`, 3 wait states:
  - `bus_wr_data = 0x12341234`, `bus_be = 4'b1100`, `bus_rw = 0`.
  - `stall` is high for 5 cycles.
- R_W with `ex_out = 0x2001`: `miss_align = LOAD`, `bus_as_` stays 1, `stall = 0`, `out = 0`. W_H with `ex_out = 0x2001`: `miss_align = STORE`.
- `TIMEOUT = 4` and ready never asserted: 4 BUS cycles, then DONE with `bus_err = 1` and `out = 0`, then IDLE with `bus_err = 0`.
- `reset_ = 0` during the second BUS cycle: the next cycle has `bus_as_ = 1`, `stall = 0`, and the FSM in IDLE. A later R_W completes normally.
- Back-to-back loads followed by a non-memory op with `ex_out = 0x55`: each load gets exactly one bus strobe and the NOP gives `out = 0x55` with no stall.
